// File: rtl/serdes_pkg.sv
// Shared definitions for the team's serial/parallel conversion blocks.
package serdes_pkg;

   // Default word width used by the serdes blocks when not overridden.
   localparam int SerdesWidth = 8;

   // Deserialiser control states: RX collects bits, HOLD parks a finished
   // word in the shift register while the output register is still occupied.
   typedef enum logic {
      RX   = 1'b0,
      HOLD = 1'b1
   } s2p_state_e;

endpackage

// File: rtl/s2p.sv
// Serial-to-parallel converter: collects N serial bits LSB-first into a word
// and presents it on a valid/ready parallel output with an inline output
// register. A second finished word can wait in the shift register (HOLD)
// while the output register is still occupied.
module s2p
   import serdes_pkg::*;
#(
   parameter int N = SerdesWidth
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ser_valid,
   input  logic         ser_data,
   output logic         ser_ready,
   input  logic         par_ready,
   output logic         par_valid,
   output logic [N-1:0] par_data
);

   localparam int CntW = $clog2(N);
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   s2p_state_e    state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  shift_q, shift_d;
   logic [N-1:0]  data_q, data_d;
   logic          valid_q, valid_d;

   logic          serBeat;
   logic          parTake;

   // Ready depends only on the registered state, so par_ready never reaches ser_ready.
   assign ser_ready = (state_q == RX);
   assign par_valid = valid_q;
   assign par_data  = data_q;

   assign serBeat = ser_valid && ser_ready;
   assign parTake = valid_q && par_ready;

   // Next-state logic: place each accepted bit at its index, hand finished
   // words to the output register when it is free, otherwise park in HOLD.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;

      if (parTake) begin
         valid_d = 1'b0;
      end

      case (state_q)
         RX: begin
            if (serBeat) begin
               shift_d[cnt_q] = ser_data;
               if (cnt_q == LastCnt) begin
                  cnt_d = '0;
                  if (!valid_q || par_ready) begin
                     data_d  = shift_d;
                     valid_d = 1'b1;
                  end else begin
                     state_d = HOLD;
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         HOLD: begin
            if (parTake) begin
               data_d  = shift_q;
               valid_d = 1'b1;
               state_d = RX;
            end
         end
         default: begin
            state_d = RX;
         end
      endcase
   end

   // State, counter, shift and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RX;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

endmodule
